pe_array_seq: RTL and testbench
===============================

Name: pe_array_seq

Overview:
- Sequencer sitting in front of one pe_array instance.
- Accepts a job (reduction length K, tile count T, shift, pass-left mask) and merges a weight stream and an activation stream into per-cycle beats on the array inputs.
- Asserts clear-acc at tile boundaries and captures each tile's result after a fixed latency into a small output FIFO.
- Issues new tiles only when result space is guaranteed, because pe_array has no stall input.

Parameters:
- ARRAY_NUM, 3, PEs in the array; activation/result width is 8*ARRAY_NUM.
- KLEN_W, 8, width of K and T fields.
- RES_LAT, 5, cycles from a clear-acc driven on oArrClearAcc to the finished result of the preceding tile being stable on iArrResult.
- OUT_DEPTH, 2, result FIFO depth (>=1).

Ports:
- iClk  in  1  clock
- iRstN  in  1  asynchronous active-low reset
- iStart  in  1  job start pulse; sampled only in IDLE
- iKLen  in  KLEN_W  beats per tile (K)
- iNumTiles  in  KLEN_W  tiles per job (T)
- iShift  in  5  result shift amount
- iPassMask  in  ARRAY_NUM-1  pass-data-left config
- oBusy  out  1  high outside IDLE
- oDone  out  1  one-cycle pulse at job end
- iWtValid  in  1  weight stream valid
- iWtData  in  8  weight byte
- oWtReady  out  1  weight accepted
- iActValid  in  1  activation stream valid
- iActData  in  8*ARRAY_NUM  activation vector
- oActReady  out  1  activation accepted
- oArrWeight  out  8  to pe_array weight input
- oArrData  out  8*ARRAY_NUM  to pe_array data input
- oArrClearAcc  out  1  to pe_array clear-acc input
- oArrPassLeft  out  ARRAY_NUM-1  to pe_array pass-data-left input
- oArrShift  out  5  to pe_array output shift
- iArrResult  in  8*ARRAY_NUM  from pe_array result output
- oResValid  out  1  result FIFO head valid
- oResData  out  8*ARRAY_NUM  result FIFO head
- oResLast  out  1  head is the job's final tile
- iResReady  in  1  result consumer ready

Behaviour:
- Reset:
  - All registers clear.
  - All outputs are 0; FSM goes to IDLE and the FIFO and token pipe empty.
  - Reset mid-job abandons the job; no oDone.
- Config:
  - iKLen, iNumTiles, iShift and iPassMask are latched on an accepted iStart.
  - oArrShift and oArrPassLeft drive the latched values and hold them until the next accepted start.
- FSM states: IDLE, RUN, FLUSH, DRAIN, DONE.
  - IDLE: on iStart, if K==0 or T==0, go to DONE with no array activity. Otherwise latch config, clear beat and tile counters, go to RUN.
  - iStart outside IDLE is ignored.
- Beat fire (RUN): fire = iWtValid & iActValid & gate.
  - gate = 1 except on the first beat of a tile.
  - On a tile's first beat, gate = (inflight + fifo_count <= OUT_DEPTH-1).
  - oWtReady = oActReady = fire; both streams consume together.
- Array drive (registered, 1-cycle latency):
  - Fire in cycle n puts the weight and data on oArrWeight/oArrData at n+1.
  - oArrClearAcc at n+1 equals (beat counter == 0) for that beat.
  - A non-fire cycle drives zero weight, zero data and clear=0, so bubbles add nothing.
- Counters and transitions:
  - The beat counter wraps at K-1 and then increments the tile counter.
  - After the last beat of tile T-1, go to FLUSH.
- FLUSH:
  - Waits for inflight + fifo_count <= OUT_DEPTH-1.
  - Then drives one zero beat with clear=1 and goes to DRAIN.
- Token pipe (RES_LAT stages):
  - A token enters when a clear is driven on oArrClearAcc for tile t>=1, or by the flush beat. It carries last = (flush beat).
  - inflight = number of tokens in the pipe.
  - A token exiting captures iArrResult and last into the FIFO.
  - The credit rule guarantees the FIFO is never full at capture; the bench asserts this.
- FIFO: standard valid/ready; oResValid = not empty; pop on oResValid & iResReady.
- DRAIN: when inflight==0 and the FIFO is empty, go to DONE.
- DONE: oDone=1 for one cycle, then IDLE; oBusy drops in the same cycle as the IDLE entry.
- Simultaneous FIFO push and pop is allowed at any occupancy, including full with pop.

Test Plan:
- K=4, T=1, streams always valid, iResReady=1 -> 4 beats on consecutive cycles with clear on the first; flush clear 4 cycles after it; one result with oResLast=1 RES_LAT cycles after flush; oDone after the FIFO empties.
- K=2, T=4, iResReady=0 until done is expected -> tile 3 start and flush are withheld; at most OUT_DEPTH results buffered; on release, 4 results in order, last flag only on the 4th; no FIFO overflow.
- K=3, T=2, iWtValid toggling every other cycle -> no fire while either stream is invalid; zero bubbles on the array ports; beat and tile counts are exact; 2 results.
- iStart with K=0 (T=5) -> oDone pulse within 2 cycles; oWtReady never asserts; no results.
- iStart pulsed again mid-job with different K -> ignored; job completes with the original config; oArrShift unchanged.
- Reset asserted during RUN of a K=8, T=3 job -> all outputs 0 immediately; FIFO empty; no oDone; a new job after reset completes normally.

Source files
------------

// File: rtl/pe_array_seq.sv
// pe_array_seq: job sequencer in front of a pe_array.
// Merges weight/activation streams into array beats, issues clear-acc at
// tile boundaries, and captures each tile's result into a small FIFO.
module pe_array_seq #(
    parameter int ARRAY_NUM = 3,
    parameter int KLEN_W    = 8,
    parameter int RES_LAT   = 5,
    parameter int OUT_DEPTH = 2
) (
    input  logic                   iClk,
    input  logic                   iRstN,
    input  logic                   iStart,
    input  logic [KLEN_W-1:0]      iKLen,
    input  logic [KLEN_W-1:0]      iNumTiles,
    input  logic [4:0]             iShift,
    input  logic [ARRAY_NUM-2:0]   iPassMask,
    output logic                   oBusy,
    output logic                   oDone,
    input  logic                   iWtValid,
    input  logic [7:0]             iWtData,
    output logic                   oWtReady,
    input  logic                   iActValid,
    input  logic [8*ARRAY_NUM-1:0] iActData,
    output logic                   oActReady,
    output logic [7:0]             oArrWeight,
    output logic [8*ARRAY_NUM-1:0] oArrData,
    output logic                   oArrClearAcc,
    output logic [ARRAY_NUM-2:0]   oArrPassLeft,
    output logic [4:0]             oArrShift,
    input  logic [8*ARRAY_NUM-1:0] iArrResult,
    output logic                   oResValid,
    output logic [8*ARRAY_NUM-1:0] oResData,
    output logic                   oResLast,
    input  logic                   iResReady
);

    localparam int AW = 8*ARRAY_NUM;
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH+1);
    localparam int unsigned CREDIT = OUT_DEPTH - 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [KLEN_W-1:0]     k_len, num_tiles, beat_cnt, tile_cnt;
    logic [4:0]            shift_q;
    logic [ARRAY_NUM-2:0]  mask_q;
    logic [7:0]            arr_wt;
    logic [AW-1:0]         arr_data;
    logic                  arr_clear;
    logic                  tok_pend, pend_last;
    logic [RES_LAT-1:0]    tok_v, tok_last;
    logic [AW:0]           fifo_mem [OUT_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         fifo_cnt;
    int unsigned           inflight;
    logic                  first_beat, last_beat, last_tile, credit_ok;
    logic                  fire, flush_go, cfg_zero, push, pop;

    // Tokens in flight; the one riding with the clear just driven counts too,
    // so back-to-back tile starts (K=1) cannot oversubscribe the FIFO.
    always_comb begin
        inflight = 0;
        if (tok_pend) inflight = inflight + 1;
        for (int unsigned i = 0; i < RES_LAT; i++)
            if (tok_v[i]) inflight = inflight + 1;
    end

    // Beat firing, credit check and next-state selection.
    always_comb begin
        first_beat = (beat_cnt == '0);
        last_beat  = (beat_cnt == k_len - KLEN_W'(1));
        last_tile  = (tile_cnt == num_tiles - KLEN_W'(1));
        credit_ok  = (inflight + 32'(fifo_cnt)) <= CREDIT;
        cfg_zero   = (iKLen == '0) || (iNumTiles == '0);
        fire       = (state == S_RUN) && iWtValid && iActValid && (!first_beat || credit_ok);
        flush_go   = (state == S_FLUSH) && credit_ok;
        state_nxt  = state;
        case (state)
            S_IDLE:  if (iStart) state_nxt = cfg_zero ? S_DONE : S_RUN;
            S_RUN:   if (fire && last_beat && last_tile) state_nxt = S_FLUSH;
            S_FLUSH: if (flush_go) state_nxt = S_DRAIN;
            S_DRAIN: if (inflight == 0 && fifo_cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Job config latch and beat/tile counters.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            k_len <= '0; num_tiles <= '0; shift_q <= '0; mask_q <= '0;
            beat_cnt <= '0; tile_cnt <= '0;
        end else if (state == S_IDLE && iStart && !cfg_zero) begin
            k_len <= iKLen; num_tiles <= iNumTiles; shift_q <= iShift; mask_q <= iPassMask;
            beat_cnt <= '0; tile_cnt <= '0;
        end else if (fire) begin
            if (last_beat) begin
                beat_cnt <= '0;
                tile_cnt <= tile_cnt + KLEN_W'(1);
            end else begin
                beat_cnt <= beat_cnt + KLEN_W'(1);
            end
        end
    end

    // Registered array drive; non-fire cycles drive a zero bubble.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            arr_wt <= '0; arr_data <= '0; arr_clear <= 1'b0;
            tok_pend <= 1'b0; pend_last <= 1'b0;
        end else begin
            arr_wt    <= fire ? iWtData : '0;
            arr_data  <= fire ? iActData : '0;
            arr_clear <= (fire && first_beat) || flush_go;
            tok_pend  <= (fire && first_beat && tile_cnt != '0) || flush_go;
            pend_last <= flush_go;
        end
    end

    // Result-latency token pipe.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            tok_v <= '0; tok_last <= '0;
        end else begin
            tok_v[0]    <= tok_pend;
            tok_last[0] <= pend_last;
            for (int unsigned i = 1; i < RES_LAT; i++) begin
                tok_v[i]    <= tok_v[i-1];
                tok_last[i] <= tok_last[i-1];
            end
        end
    end

    assign push = tok_v[RES_LAT-1];
    assign pop  = (fifo_cnt != '0) && iResReady;

    // Result FIFO.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr <= '0; rd_ptr <= '0; fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {tok_last[RES_LAT-1], iArrResult};
                wr_ptr <= (wr_ptr == PW'(OUT_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= (rd_ptr == PW'(OUT_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    assign oBusy        = (state != S_IDLE);
    assign oDone        = (state == S_DONE);
    assign oWtReady     = fire;
    assign oActReady    = fire;
    assign oArrWeight   = arr_wt;
    assign oArrData     = arr_data;
    assign oArrClearAcc = arr_clear;
    assign oArrPassLeft = mask_q;
    assign oArrShift    = shift_q;
    assign oResValid    = (fifo_cnt != '0);
    assign oResData     = fifo_mem[rd_ptr][AW-1:0];
    assign oResLast     = fifo_mem[rd_ptr][AW];

endmodule

// File: tb/tb_pe_array_seq.sv
// Directed bench for pe_array_seq with a stand-in pe_array result source.
module tb_pe_array_seq;
    localparam int RES_LAT   = 5;
    localparam int OUT_DEPTH = 2;

    logic        iClk = 1'b0;
    logic        iRstN, iStart, iWtValid, iActValid, iResReady;
    logic [7:0]  iKLen, iNumTiles, iWtData;
    logic [4:0]  iShift;
    logic [1:0]  iPassMask;
    logic [23:0] iActData, iArrResult;
    logic        oBusy, oDone, oWtReady, oActReady, oArrClearAcc, oResValid, oResLast;
    logic [7:0]  oArrWeight;
    logic [23:0] oArrData, oResData;
    logic [1:0]  oArrPassLeft;
    logic [4:0]  oArrShift;

    pe_array_seq #(.ARRAY_NUM(3), .KLEN_W(8), .RES_LAT(RES_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iKLen(iKLen), .iNumTiles(iNumTiles),
        .iShift(iShift), .iPassMask(iPassMask), .oBusy(oBusy), .oDone(oDone),
        .iWtValid(iWtValid), .iWtData(iWtData), .oWtReady(oWtReady),
        .iActValid(iActValid), .iActData(iActData), .oActReady(oActReady),
        .oArrWeight(oArrWeight), .oArrData(oArrData), .oArrClearAcc(oArrClearAcc),
        .oArrPassLeft(oArrPassLeft), .oArrShift(oArrShift), .iArrResult(iArrResult),
        .oResValid(oResValid), .oResData(oResData), .oResLast(oResLast), .iResReady(iResReady)
    );

    always #5 iClk = ~iClk;

    int n_tests = 0, n_fail = 0;
    logic [31:0] cyc = 0, wcnt = 0;

    // Stand-in array result: a distinct value every cycle.
    function automatic logic [23:0] res_of(input logic [31:0] c);
        return {c[7:0] ^ 8'hA5, c[7:0], ~c[7:0]};
    endfunction

    always @(posedge iClk) cyc <= cyc + 1;
    always @(posedge iClk) if (oWtReady) wcnt <= wcnt + 1;
    assign iArrResult = res_of(cyc);
    assign iWtData    = {wcnt[6:0], 1'b1};
    assign iActData   = {~wcnt[7:0], wcnt[7:0] ^ 8'h5A, wcnt[7:0] | 8'h80};

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Job model
    int job_k = 1, job_t = 1, beats = 0, clears = 0, pops = 0, done_cnt = 0;
    bit first_clear_done = 0, flush_seen = 0, wt_seen = 0, prev_fire = 0, prev_clr = 0;
    logic [7:0]  prev_wt;
    logic [23:0] prev_act;
    logic [23:0] exp_q[$];
    int first_clear_cyc, flush_cyc, first_valid_cyc, last_pop_cyc, done_cyc;

    // Cycle monitor: array drive, token scoreboard, result checks.
    always @(negedge iClk) begin
        if (!iRstN) begin
            prev_fire = 0;
        end else begin
            bit clr_ev;
            clr_ev = 0;
            chk(32'(oActReady), 32'(oWtReady), "ready_pair");
            if (oWtReady) chk(32'(iWtValid && iActValid), 1, "fire_needs_valid");
            if (prev_fire) begin
                chk(32'(oArrWeight), 32'(prev_wt), "arr_weight");
                chk(32'(oArrData), 32'(prev_act), "arr_data");
                chk(32'(oArrClearAcc), 32'(prev_clr), "arr_clear");
                clr_ev = oArrClearAcc;
            end else begin
                chk(32'(oArrWeight), 0, "bubble_weight");
                chk(32'(oArrData), 0, "bubble_data");
                if (oArrClearAcc) begin
                    chk(32'(beats == job_k*job_t && !flush_seen), 1, "flush_when");
                    flush_seen = 1;
                    flush_cyc = int'(cyc);
                    clr_ev = 1;
                end
            end
            if (clr_ev) begin
                if (first_clear_done) exp_q.push_back(res_of(cyc + RES_LAT));
                else first_clear_cyc = int'(cyc);
                first_clear_done = 1;
                clears++;
            end
            chk(32'(exp_q.size() <= OUT_DEPTH), 1, "fifo_credit");
            if (oResValid && first_valid_cyc < 0) first_valid_cyc = int'(cyc);
            if (oResValid && iResReady) begin
                if (exp_q.size() == 0) chk(32'(oResData), 32'hDEAD, "unexpected_result");
                else chk(32'(oResData), 32'(exp_q.pop_front()), "res_data");
                chk(32'(oResLast), 32'(pops == job_t-1), "res_last");
                pops++;
                last_pop_cyc = int'(cyc);
            end
            prev_fire = oWtReady;
            prev_wt   = iWtData;
            prev_act  = iActData;
            if (oWtReady) begin
                prev_clr = ((beats % ((job_k == 0) ? 1 : job_k)) == 0);
                beats++;
                wt_seen = 1;
            end
            if (oDone) begin
                done_cnt++;
                done_cyc = int'(cyc);
            end
        end
    end

    task automatic start_job(input int k, input int t, input logic [4:0] sh, input logic [1:0] pm);
        job_k = k; job_t = t; beats = 0; clears = 0; pops = 0;
        first_clear_done = 0; flush_seen = 0; wt_seen = 0; exp_q.delete();
        first_valid_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
        iKLen = 8'(k); iNumTiles = 8'(t); iShift = sh; iPassMask = pm; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        if (k != 0 && t != 0) begin
            chk(32'(oArrShift), 32'(sh), "cfg_shift");
            chk(32'(oArrPassLeft), 32'(pm), "cfg_mask");
        end
    endtask

    task automatic wait_done(input int maxc, input bit toggle, output int took);
        int d0;
        d0 = done_cnt;
        took = -1;
        for (int i = 0; i < maxc; i++) begin
            @(posedge iClk); #1;
            if (toggle) iWtValid = ~iWtValid;
            if (done_cnt != d0) begin
                took = i;
                break;
            end
        end
        chk(32'(took >= 0), 1, "done_timeout");
        chk(32'(done_cnt - d0), 1, "done_once");
        chk(32'(oBusy), 0, "busy_after_done");
        iWtValid = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk(32'({oBusy, oDone, oWtReady, oActReady, oArrClearAcc, oResValid, oResLast}), 0, {tag, "_flags"});
        chk(32'(oArrWeight), 0, {tag, "_weight"});
        chk(32'(oArrData), 0, {tag, "_data"});
        chk(32'({oArrPassLeft, oArrShift}), 0, {tag, "_cfg"});
        chk(32'(oResData), 0, {tag, "_resdata"});
    endtask

    initial begin
        #500000;
        $error("FAIL global_timeout: observed running expected finished");
        $fatal;
    end

    initial begin
        int took, d;
        iRstN = 1'b0; iStart = 1'b0; iKLen = '0; iNumTiles = '0; iShift = '0; iPassMask = '0;
        iWtValid = 1'b1; iActValid = 1'b1; iResReady = 1'b1;
        #1;
        check_zero("reset");
        repeat (2) @(posedge iClk);
        #1 iRstN = 1'b1;
        @(posedge iClk); #1;

        // K=4, T=1: four back-to-back beats, flush, one last-flagged result.
        start_job(4, 1, 5'd3, 2'b01);
        wait_done(100, 0, took);
        chk(32'(beats), 4, "t1_beats");
        chk(32'(clears), 2, "t1_clears");
        chk(32'(pops), 1, "t1_results");
        chk(32'(flush_cyc - first_clear_cyc), 4, "t1_flush_gap");
        chk(32'(first_valid_cyc - flush_cyc), RES_LAT + 1, "t1_res_latency");
        chk(32'(done_cyc > last_pop_cyc), 1, "t1_done_after_drain");

        // K=2, T=4 with consumer stalled: tile 3 and flush withheld.
        iResReady = 1'b0;
        start_job(2, 4, 5'd9, 2'b10);
        repeat (40) @(posedge iClk);
        #1;
        chk(32'(beats), 6, "t2_withheld_beats");
        chk(32'(flush_seen), 0, "t2_no_flush");
        chk(32'(oResValid), 1, "t2_res_buffered");
        chk(32'(oBusy), 1, "t2_busy");
        iResReady = 1'b1;
        wait_done(200, 0, took);
        chk(32'(beats), 8, "t2_beats");
        chk(32'(pops), 4, "t2_results");

        // K=3, T=2 with weight valid toggling.
        start_job(3, 2, 5'd1, 2'b11);
        wait_done(200, 1, took);
        chk(32'(beats), 6, "t3_beats");
        chk(32'(clears), 3, "t3_clears");
        chk(32'(pops), 2, "t3_results");

        // K=0: immediate done, no array activity.
        start_job(0, 5, 5'd4, 2'b00);
        wait_done(3, 0, took);
        chk(32'(took <= 1), 1, "t4_done_fast");
        chk(32'(wt_seen), 0, "t4_no_ready");
        chk(32'(pops + clears), 0, "t4_no_activity");

        // Mid-job start with a different config is ignored.
        start_job(3, 2, 5'd7, 2'b01);
        repeat (3) @(posedge iClk);
        #1;
        iKLen = 8'd5; iShift = 5'd1; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        wait_done(200, 0, took);
        chk(32'(beats), 6, "t5_beats");
        chk(32'(pops), 2, "t5_results");
        chk(32'(oArrShift), 7, "t5_shift_kept");

        // Reset during RUN, then a fresh job.
        start_job(8, 3, 5'd2, 2'b10);
        repeat (10) @(posedge iClk);
        #3;
        d = done_cnt;
        iRstN = 1'b0;
        #1;
        check_zero("midreset");
        @(posedge iClk); #1;
        iRstN = 1'b1;
        repeat (20) @(posedge iClk);
        #1;
        chk(32'(done_cnt), 32'(d), "t6_no_done");
        chk(32'(oResValid), 0, "t6_fifo_empty");
        start_job(2, 2, 5'd6, 2'b01);
        wait_done(200, 0, took);
        chk(32'(pops), 2, "t6_results");
        chk(32'(beats), 4, "t6_beats");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
